// File: rtl/pipe_stage_reg_if.sv
// Valid/ready handshake bundle for pipe_stage_reg: upstream (in_*) and downstream (out_*) channels.
// The master modport is the environment side, the slave modport is the stage itself.
interface pipe_stage_reg_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/pipe_stage_reg.sv
// Registered valid/ready pipeline stage with flush and a saturating stall counter.
// Define PIPE_STAGE_SKID_EN for the two-entry skid buffer; otherwise a single-entry stage.
//
// state | meaning (PIPE_STAGE_SKID_EN only)
// EMPTY | no payload held
// FULL  | main register holds the output payload
// SKID  | main and skid both hold payloads, upstream is back-pressured
module pipe_stage_reg #(
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int               CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  pipe_stage_reg_if.slave  bus,
  input  logic             flush,
  output logic [CNT_W-1:0] stall_count
);

  logic             out_valid_q;
  logic [WIDTH-1:0] main_q;
  logic [CNT_W-1:0] stall_q;
  logic             accept;
  logic             pop;

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = main_q;
  assign stall_count   = stall_q;

  assign accept = bus.in_valid && bus.in_ready;
  assign pop    = out_valid_q && bus.out_ready;

`ifdef PIPE_STAGE_SKID_EN
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic             skid_valid_q;
  logic [WIDTH-1:0] skid_q;
  logic             load_main_in;
  logic             load_main_skid;
  logic             load_skid;

  // Ready depends only on a flop, so out_ready never reaches in_ready.
  assign bus.in_ready = !skid_valid_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d      = FULL;
          load_main_in = 1'b1;
        end
      end
      FULL: begin
        if (accept && pop) begin
          load_main_in = 1'b1;
        end else if (accept) begin
          state_d   = SKID;
          load_skid = 1'b1;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      SKID: begin
        if (pop) begin
          state_d        = FULL;
          load_main_skid = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (flush) begin
      state_d        = EMPTY;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
    end
  end

  // Valid bits are kept as their own flops so the outputs need no state decode.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      out_valid_q  <= (state_d != EMPTY);
      skid_valid_q <= (state_d == SKID);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      main_q <= RESET_VALUE;
      skid_q <= RESET_VALUE;
    end else begin
      if (load_main_in) begin
        main_q <= bus.in_data;
      end else if (load_main_skid) begin
        main_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= bus.in_data;
      end
    end
  end
`else
  // A pop frees the single entry in the same cycle, giving zero-bubble replacement.
  assign bus.in_ready = !out_valid_q || bus.out_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_q <= 1'b0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
    end else if (pop) begin
      out_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      main_q <= RESET_VALUE;
    end else if (accept && !flush) begin
      main_q <= bus.in_data;
    end
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_q <= '0;
    end else if (out_valid_q && !bus.out_ready && !flush && (stall_q != {CNT_W{1'b1}})) begin
      stall_q <= stall_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed self-checking bench for pipe_stage_reg in either buffering mode.
module tb_pipe_stage_reg;

  localparam int          W  = 32;
  localparam logic [31:0] RV = 32'hCAFE_0001;

  logic        clk;
  logic        reset;
  logic        flush;
  logic [15:0] stall_count;
  logic [1:0]  stall_count2;
  int          checks;
  int          errors;

  pipe_stage_reg_if #(.WIDTH(W)) bus ();
  pipe_stage_reg_if #(.WIDTH(W)) bus2 ();

  assign bus2.in_valid  = bus.in_valid;
  assign bus2.in_data   = bus.in_data;
  assign bus2.out_ready = bus.out_ready;

  pipe_stage_reg #(.WIDTH(W), .RESET_VALUE(RV), .CNT_W(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus.slave),
    .flush       (flush),
    .stall_count (stall_count)
  );

  pipe_stage_reg #(.WIDTH(W), .RESET_VALUE(RV), .CNT_W(2)) dut2 (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus2.slave),
    .flush       (flush),
    .stall_count (stall_count2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("%s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset          = 1'b0;
    flush          = 1'b0;
    bus.in_valid   = 1'b1;
    bus.in_data    = 32'hA5;
    bus.out_ready  = 1'b0;
    #2;
    step();
    step();
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data", bus.out_data, RV);
    check("rst_stall", 32'(stall_count), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);

    bus.in_valid = 1'b0;
    reset = 1'b1;
    #1;
    check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

    // back-to-back stream
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = 32'h1;
    step();
    check("stream1_valid", 32'(bus.out_valid), 32'd1);
    check("stream1_data", bus.out_data, 32'h1);
    check("stream1_ready", 32'(bus.in_ready), 32'd1);
    bus.in_data = 32'h2;
    step();
    check("stream2_valid", 32'(bus.out_valid), 32'd1);
    check("stream2_data", bus.out_data, 32'h2);
    bus.in_data = 32'h3;
    step();
    check("stream3_valid", 32'(bus.out_valid), 32'd1);
    check("stream3_data", bus.out_data, 32'h3);
    bus.in_valid = 1'b0;
    step();
    check("stream_drain", 32'(bus.out_valid), 32'd0);
    check("stream_stall", 32'(stall_count), 32'd0);

    // stall counting and saturation
    bus.in_valid  = 1'b1;
    bus.in_data   = 32'h42;
    bus.out_ready = 1'b0;
    step();
    bus.in_valid = 1'b0;
    check("hold_valid", 32'(bus.out_valid), 32'd1);
    check("hold_data", bus.out_data, 32'h42);
    check("hold_stall0", 32'(stall_count), 32'd0);
    repeat (5) step();
    check("stall5", 32'(stall_count), 32'd5);
    check("hold_data5", bus.out_data, 32'h42);
    step();
    check("stall6", 32'(stall_count), 32'd6);
    check("stall_sat", 32'(stall_count2), 32'd3);

    // flush while holding, with a competing input
    flush        = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 32'h77;
    step();
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    check("flush_valid", 32'(bus.out_valid), 32'd0);
    check("flush_in_ready", 32'(bus.in_ready), 32'd1);
    check("flush_data_kept", bus.out_data, 32'h42);
    check("flush_stall_kept", 32'(stall_count), 32'd6);
    flush        = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 32'h77;
    step();
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    check("flush_accept_dropped", 32'(bus.out_valid), 32'd0);
    check("flush_data_unchanged", bus.out_data, 32'h42);
    step();
    check("flush_stays_empty", 32'(bus.out_valid), 32'd0);

    // simultaneous pop and accept replaces the entry without a bubble
    bus.in_valid = 1'b1;
    bus.in_data  = 32'h55;
    step();
    bus.in_data   = 32'h66;
    bus.out_ready = 1'b1;
    #1;
    check("replace_in_ready", 32'(bus.in_ready), 32'd1);
    step();
    bus.in_valid = 1'b0;
    check("replace_valid", 32'(bus.out_valid), 32'd1);
    check("replace_data", bus.out_data, 32'h66);
    step();
    check("replace_drain", 32'(bus.out_valid), 32'd0);

    // back-pressure with a second payload offered
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 32'h10;
    step();
    check("bp_first_data", bus.out_data, 32'h10);
    bus.in_data = 32'h11;
    #1;
`ifdef PIPE_STAGE_SKID_EN
    check("bp_ready_before", 32'(bus.in_ready), 32'd1);
    step();
    bus.in_valid = 1'b0;
    check("skid_in_ready", 32'(bus.in_ready), 32'd0);
    check("skid_main_data", bus.out_data, 32'h10);
    bus.out_ready = 1'b1;
    step();
    check("skid_second_valid", 32'(bus.out_valid), 32'd1);
    check("skid_second_data", bus.out_data, 32'h11);
    check("skid_ready_back", 32'(bus.in_ready), 32'd1);
    step();
    check("skid_drain", 32'(bus.out_valid), 32'd0);
`else
    check("bp_ready_before", 32'(bus.in_ready), 32'd0);
    step();
    bus.in_valid = 1'b0;
    check("bp_not_taken", bus.out_data, 32'h10);
    bus.out_ready = 1'b1;
    step();
    check("bp_drain", 32'(bus.out_valid), 32'd0);
`endif

    // reset asserted while holding payloads
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 32'h20;
    step();
    bus.in_data = 32'h21;
    step();
    bus.in_valid = 1'b0;
    #3;
    reset = 1'b0;
    #1;
    check("midrst_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_data", bus.out_data, RV);
    check("midrst_stall", 32'(stall_count), 32'd0);
    check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    step();
    reset         = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = 32'h5;
    bus.out_ready = 1'b1;
    step();
    bus.in_valid = 1'b0;
    check("after_rst_valid", 32'(bus.out_valid), 32'd1);
    check("after_rst_data", bus.out_data, 32'h5);
    step();
    check("after_rst_no_stale", 32'(bus.out_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter WIDTH, default 32, payload width in bits (1..256).
REQ-002 Parameter RESET_VALUE, default 0, WIDTH-bit value loaded into data registers on reset.
REQ-003 Parameter CNT_W, default 16, stall-counter width in bits.
REQ-004 Clock and reset SHALL be: one clock; reset is asynchronous and active-low.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 reset  input  1  asynchronous active-low reset.
REQ-007 in_valid  input  1  upstream presents in_data.
REQ-008 in_ready  output  1  stage can accept in_data this cycle.
REQ-009 in_data  input  WIDTH  payload from upstream stage.
REQ-010 out_valid  output  1  out_data holds a valid payload.
REQ-011 out_ready  input  1  downstream consumes out_data this cycle.
REQ-012 out_data  output  WIDTH  registered payload to downstream stage.
REQ-013 flush  input  1  synchronous discard of all held payloads.
REQ-014 stall_count  output  CNT_W  cycles spent with out_valid=1 and out_ready=0.

Function
REQ-015 Accept = in_valid && in_ready at a rising edge; pop = out_valid && out_ready at a rising edge.
REQ-016 out_data and out_valid SHALL be driven directly from flops (no combinational path from in_* to out_*).
REQ-017 Data registers SHALL load only on accept or internal skid-to-main move; otherwise they hold value, including while out_valid=0.
REQ-018 Latency: an accepted payload appears on out_data with out_valid=1 exactly one cycle after acceptance when the stage was empty.
REQ-019 Ordering SHALL be strict FIFO; no payload is duplicated or dropped except by flush.
REQ-020 flush=1 at an edge SHALL clear all valid bits; an accept in the same cycle is discarded; data registers are unchanged.
REQ-021 After flush, out_valid=0 and in_ready=1 from the next cycle.
REQ-022 stall_count SHALL increment by 1 each edge with out_valid=1, out_ready=0, flush=0.
REQ-023 stall_count SHALL saturate at 2^CNT_W-1 and never wrap; flush does not clear it.

Reset
REQ-024 On reset assertion, out_valid=0, skid valid=0, stall_count=0, and out_data/skid data=RESET_VALUE, all immediately (asynchronously).
REQ-025 in_ready SHALL be 1 while in reset and in the first cycle after release.
REQ-026 Reset asserted mid-transfer SHALL discard all held payloads; no partial state survives.

Configuration
REQ-027 Macro PIPE_STAGE_SKID_EN selects the buffering mode.
REQ-028 With PIPE_STAGE_SKID_EN defined, the stage SHALL hold two entries (main, skid) with states EMPTY, FULL and SKID, and in_ready = !skid_valid (registered, no dependence on out_ready).
REQ-029 Skid transitions: EMPTY+accept->FULL; FULL+accept+pop->FULL (main<=in_data); FULL+accept+!pop->SKID (skid<=in_data); FULL+pop+!accept->EMPTY; SKID+pop->FULL (main<=skid); flush from any state->EMPTY.
REQ-030 Without PIPE_STAGE_SKID_EN, the stage SHALL hold one entry, in_ready = !out_valid || out_ready (combinational), and simultaneous pop and accept SHALL replace the entry with zero bubble.

Verification
REQ-031 Reset low with in_valid=1, in_data=0xA5 -> out_valid=0, out_data=RESET_VALUE, stall_count=0, in_ready=1.
REQ-032 Stream 0x1,0x2,0x3 on consecutive cycles with out_ready=1 -> out_data 0x1,0x2,0x3 on cycles 1,2,3; out_valid held 1 throughout; no bubble in either mode.
REQ-033 SKID mode: accept 0x10, then out_ready=0 and accept 0x11 -> in_ready=0 next cycle; raise out_ready -> 0x10 then 0x11 delivered, in_ready returns to 1.
REQ-034 Hold out_valid=1 with out_ready=0 for 5 cycles -> stall_count=5; with CNT_W=2 and 6 stall cycles -> stall_count=3.
REQ-035 flush=1 with in_valid=1, in_data=0x77 while holding 0x42 -> next cycle out_valid=0, in_ready=1; 0x77 and 0x42 never appear on out_data with out_valid=1.
REQ-036 Reset pulsed low while in SKID state -> out_valid=0 immediately; after release, first accepted 0x5 is the first payload delivered.
